// File: rtl/mem_burst_arbiter.sv
// ---------------------------------------------------------------------------
// mem_burst_arbiter
//
// Purpose:
//    Memory-side responder for the video burst protocol. Accepts burst
//    requests from a frame writer and a frame reader, grants one burst at a
//    time with round-robin fairness on ties, forwards the granted burst to the
//    single memory-controller burst port and returns per-beat handshakes plus
//    a one-cycle finish pulse to the owning initiator.
//
// Ports:
//    mem_clk, rst_n              clock (rising edge), async active-low reset
//    wr_burst_*                  writer channel: req/len/addr in, data_req out,
//                                data in, finish out
//    rd_burst_*                  reader channel: req/len/addr in, data_valid,
//                                data and finish out
//    mc_burst_*                  controller request: req/wr/len/addr out,
//                                finish in
//    mc_wr_data_req/mc_wr_data   controller write beat request / write data
//    mc_rd_data_valid/mc_rd_data controller read beat valid / read data
//    len_err                     sticky: beat count at finish != granted len
// ---------------------------------------------------------------------------
module mem_burst_arbiter #(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 24
) (
   input  logic                     mem_clk,
   input  logic                     rst_n,
   // writer channel
   input  logic                     wr_burst_req,
   input  logic [9:0]               wr_burst_len,
   input  logic [ADDR_BITS-1:0]     wr_burst_addr,
   output logic                     wr_burst_data_req,
   input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
   output logic                     wr_burst_finish,
   // reader channel
   input  logic                     rd_burst_req,
   input  logic [9:0]               rd_burst_len,
   input  logic [ADDR_BITS-1:0]     rd_burst_addr,
   output logic                     rd_burst_data_valid,
   output logic [MEM_DATA_BITS-1:0] rd_burst_data,
   output logic                     rd_burst_finish,
   // memory controller port
   output logic                     mc_burst_req,
   output logic                     mc_burst_wr,
   output logic [9:0]               mc_burst_len,
   output logic [ADDR_BITS-1:0]     mc_burst_addr,
   input  logic                     mc_wr_data_req,
   output logic [MEM_DATA_BITS-1:0] mc_wr_data,
   input  logic                     mc_rd_data_valid,
   input  logic [MEM_DATA_BITS-1:0] mc_rd_data,
   input  logic                     mc_burst_finish,
   output logic                     len_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   // Grant bookkeeping. r_pend marks a grant latched in IDLE that has not yet
   // been issued; issuing one cycle later gives the registered controller
   // request its one-cycle latency from the latched len/addr.
   logic                   r_pend;
   logic                   r_own_rd;
   logic                   r_last_rd;
   logic [9:0]             r_len;
   logic [ADDR_BITS-1:0]   r_addr;
   logic [9:0]             r_cnt;

   logic                   r_mc_req;
   logic                   r_mc_wr;
   logic [9:0]             r_mc_len;
   logic [ADDR_BITS-1:0]   r_mc_addr;
   logic                   r_wr_fin;
   logic                   r_rd_fin;
   logic                   r_len_err;

   logic                   w_grant_rd;
   logic                   w_grant_wr;
   logic                   w_grant;
   logic                   w_issue;
   logic                   w_beat;
   logic                   w_done;
   logic [9:0]             w_cnt_final;

   // On a tie the channel not granted last wins; r_last_rd resets to write,
   // so the reader wins the first tie.
   assign w_grant_rd  = rd_burst_req & (~wr_burst_req | ~r_last_rd);
   assign w_grant_wr  = wr_burst_req & (~rd_burst_req |  r_last_rd);
   assign w_grant     = (r_state == IDLE) & ~r_pend & (w_grant_rd | w_grant_wr);
   assign w_issue     = (r_state == IDLE) &  r_pend;
   assign w_beat      = ((r_state == WR) & mc_wr_data_req) |
                        ((r_state == RD) & mc_rd_data_valid);
   assign w_done      = ((r_state == WR) | (r_state == RD)) & mc_burst_finish;
   // A beat arriving in the same cycle as finish still counts toward the total.
   assign w_cnt_final = w_beat ? (r_cnt + 10'd1) : r_cnt;

   // Combinational beat pass-through, gated to the owning state.
   assign wr_burst_data_req   = (r_state == WR) & mc_wr_data_req;
   assign mc_wr_data          = (r_state == WR) ? wr_burst_data : '0;
   assign rd_burst_data_valid = (r_state == RD) & mc_rd_data_valid;
   assign rd_burst_data       = (r_state == RD) ? mc_rd_data : '0;

   assign mc_burst_req    = r_mc_req;
   assign mc_burst_wr     = r_mc_wr;
   assign mc_burst_len    = r_mc_len;
   assign mc_burst_addr   = r_mc_addr;
   assign wr_burst_finish = r_wr_fin;
   assign rd_burst_finish = r_rd_fin;
   assign len_err         = r_len_err;

   // State register
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic. HOLD never looks at requests, so a req still high the
   // cycle after finish cannot retrigger a grant.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (r_pend) begin
               if (r_len == 10'd0) begin
                  w_state_next = HOLD;
               end else if (r_own_rd) begin
                  w_state_next = RD;
               end else begin
                  w_state_next = WR;
               end
            end
         end
         WR, RD: begin
            if (mc_burst_finish) begin
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Grant latch, controller request, beat counter, finish pulses, len_err
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend    <= 1'b0;
         r_own_rd  <= 1'b0;
         r_last_rd <= 1'b0;
         r_len     <= '0;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_mc_req  <= 1'b0;
         r_mc_wr   <= 1'b0;
         r_mc_len  <= '0;
         r_mc_addr <= '0;
         r_wr_fin  <= 1'b0;
         r_rd_fin  <= 1'b0;
         r_len_err <= 1'b0;
      end else begin
         r_wr_fin <= 1'b0;
         r_rd_fin <= 1'b0;

         if (w_grant) begin
            r_pend    <= 1'b1;
            r_own_rd  <= w_grant_rd;
            r_last_rd <= w_grant_rd;
            r_len     <= w_grant_rd ? rd_burst_len  : wr_burst_len;
            r_addr    <= w_grant_rd ? rd_burst_addr : wr_burst_addr;
         end

         if (w_issue) begin
            r_pend <= 1'b0;
            if (r_len == 10'd0) begin
               // Empty burst completes locally without touching the controller.
               r_wr_fin <= ~r_own_rd;
               r_rd_fin <=  r_own_rd;
            end else begin
               r_mc_req  <= 1'b1;
               r_mc_wr   <= ~r_own_rd;
               r_mc_len  <= r_len;
               r_mc_addr <= r_addr;
            end
         end

         if (w_done) begin
            r_mc_req <= 1'b0;
            r_mc_wr  <= 1'b0;
            r_wr_fin <= (r_state == WR);
            r_rd_fin <= (r_state == RD);
            r_cnt    <= '0;
            if (w_cnt_final != r_len) begin
               r_len_err <= 1'b1;
            end
         end else if (w_beat) begin
            r_cnt <= r_cnt + 10'd1;
         end
      end
   end

endmodule

// File: doc/mem_burst_arbiter.md
# mem_burst_arbiter

Memory-side responder for the video burst protocol driven by the frame writer (`wr_burst_*`) and frame reader (`rd_burst_*`) channels. It accepts requests from both initiators and grants one burst at a time, alternating fairly between them. It forwards the granted burst to the single memory-controller burst port and returns per-beat handshakes and a finish pulse to the owning initiator. It sits in the `mem_clk` domain between the video processing blocks and the SDRAM/DDR controller.

## Interface
- `MEM_DATA_BITS`, 64, memory data width.
- `ADDR_BITS`, 24, burst address width.
- `mem_clk`  in  1  memory clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_burst_req`  in  1  write request; held with len/addr until finish.
- `wr_burst_len`  in  10  write beats.
- `wr_burst_addr`  in  ADDR_BITS  write start address.
- `wr_burst_data_req`  out  1  beat request to writer.
- `wr_burst_data`  in  MEM_DATA_BITS  write beat data.
- `wr_burst_finish`  out  1  one-cycle write-complete pulse.
- `rd_burst_req`  in  1  read request.
- `rd_burst_len`  in  10  read beats.
- `rd_burst_addr`  in  ADDR_BITS  read start address.
- `rd_burst_data_valid`  out  1  read beat valid.
- `rd_burst_data`  out  MEM_DATA_BITS  read beat data.
- `rd_burst_finish`  out  1  one-cycle read-complete pulse.
- `mc_burst_req`  out  1  request to controller.
- `mc_burst_wr`  out  1  1 = write burst, 0 = read burst.
- `mc_burst_len`  out  10  beats.
- `mc_burst_addr`  out  ADDR_BITS  start address.
- `mc_wr_data_req`  in  1  controller beat request; data due next cycle.
- `mc_wr_data`  out  MEM_DATA_BITS  write data to controller.
- `mc_rd_data_valid`  in  1  controller read beat valid.
- `mc_rd_data`  in  MEM_DATA_BITS  controller read data.
- `mc_burst_finish`  in  1  controller one-cycle completion pulse.
- `len_err`  out  1  sticky; beat count at finish differed from granted length.

## Operation
- **States:** IDLE, WR, RD, HOLD.
- **Arbitration in IDLE:**
  - If only one request is high, grant it.
  - If both are high, grant the channel not granted last. `last_grant` resets to write, so read wins the first tie.
  - Latch len and addr into registers at grant, and update `last_grant`.
- **Non-zero length grant:**
  - Go to WR or RD.
  - Register `mc_burst_req`=1, `mc_burst_wr`, `mc_burst_len` and `mc_burst_addr` from the latched values.
  - Hold them until `mc_burst_finish`.
- **Zero length grant:**
  - Go straight to HOLD and pulse the matching finish.
  - No controller access; beat counter untouched; no error.
- **WR state:**
  - `wr_burst_data_req` = `mc_wr_data_req` (combinational).
  - `mc_wr_data` = `wr_burst_data` (combinational). The writer supplies data one cycle after `data_req`, which meets the controller's next-cycle rule.
  - The 10-bit beat counter increments on each `mc_wr_data_req`.
- **RD state:**
  - `rd_burst_data_valid` = `mc_rd_data_valid`.
  - `rd_burst_data` = `mc_rd_data`.
  - The beat counter increments on each valid.
- **Outside the owning state:** `wr_burst_data_req` and `rd_burst_data_valid` are forced to 0, and `mc_wr_data` and `rd_burst_data` are driven to 0.
- **On `mc_burst_finish` in WR or RD:**
  - Deassert `mc_burst_req` next cycle.
  - Pulse `wr_burst_finish` or `rd_burst_finish` for exactly one cycle (registered).
  - Set `len_err` if beat count != latched len.
  - Clear the counter and go to HOLD.
- **HOLD:** lasts one cycle, then IDLE. Requests are ignored in HOLD because an initiator's req may still be high the cycle after finish.
- **Spurious controller signals:** `mc_burst_finish` in IDLE or HOLD is ignored.
- **Request withdrawal:** an initiator dropping req mid-burst does not abort; the burst completes and finish still pulses.
- **Beat counter:** wraps modulo 1024; `len` = 1023 is legal.
- **Clearing `len_err`:** only reset clears it.

## Timing
- **Reset:** asynchronous assertion; all outputs 0, state IDLE, `last_grant` = write, counter 0, `len_err` 0. A reset mid-burst drops `mc_burst_req` immediately.
- **Grant latency:** req sampled high in IDLE at edge N gives `mc_burst_req` = 1 after edge N+1.
- **Data path:** zero-cycle combinational pass-through.
- **Finish latency:** `mc_burst_finish` at edge M gives initiator finish high during cycle M+1 and `mc_burst_req` low in the same cycle.
- **Earliest re-grant:** state is IDLE at M+2, so the earliest next `mc_burst_req` is M+3.

## Test plan
- **Single write:** `wr_burst_req`, len = 4, addr = 0x000100; controller issues 4 `data_req` then finish. Expect `mc_burst_addr` = 0x000100, `mc_burst_wr` = 1, data 1..4 forwarded in order, one `wr_burst_finish` pulse, `len_err` = 0.
- **Tie and fairness:**
  - Both reqs high after reset: read granted first, then write; each finish goes only to its owner.
  - Repeat with both held high: grants alternate RD, WR, RD, WR.
- **Zero length:** `rd_burst_len` = 0. Expect `rd_burst_finish` 2 cycles after req, no `mc_burst_req`.
- **Length mismatch:** read len = 8, controller returns 7 valids then finish. Expect `len_err` = 1 and held through the next good burst.
- **HOLD guard:** initiator keeps req high one cycle after finish. Expect no second grant for that cycle; next grant only if req is still high in IDLE.
- **Reset mid-burst:** assert `rst_n` low after beat 3 of 16. Expect all outputs 0 asynchronously. After release with no reqs, expect state IDLE and no finish pulse.
